// File: rtl/asym_fifo_write_wider_pkg.sv
`default_nettype none
// ============================================================================
// Module   : asym_fifo_write_wider_pkg
// Brief    : Shared types for the write-wider / read-narrower FIFO.
//            Optional feature macro: ASYM_FIFO_LAST_EN.
// Revision : 1.0 - initial release
// ============================================================================
package asym_fifo_write_wider_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        WAIT  = 2'd1,
        VALID = 2'd2
    } rd_state_t;

    localparam int RATIO_DEFAULT = 8;
    localparam int LOG2_RATIO    = $clog2(RATIO_DEFAULT);

    typedef logic [LOG2_RATIO-1:0] sub_idx_t;

endpackage
`default_nettype wire

// File: rtl/asym_fifo_write_wider_ram_sdp_wide.sv
`default_nettype none
// ============================================================================
// Module   : ram_sdp_wide
// Brief    : Simple dual-port RAM (write port A, registered read port B)
//            followed by LATENCY-1 delay stages and a matching valid chain.
// Revision : 1.0 - initial release
// ============================================================================
module ram_sdp_wide #(
    parameter int DW      = 64,
    parameter int DEPTH   = 256,
    parameter int AW      = 8,
    parameter int LATENCY = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid
);

    logic [DW-1:0]                mem [DEPTH];
    logic [LATENCY-1:0][DW-1:0]   dat_q;
    logic [LATENCY-1:0]           vld_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            dat_q[0] <= mem[rd_addr];
        end
        for (int i = 1; i < LATENCY; i++) begin
            dat_q[i] <= dat_q[i-1];
        end
    end

    // Only the valid tags are reset: a reset discards every read in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= rd_en;
            for (int i = 1; i < LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    assign rd_data  = dat_q[LATENCY-1];
    assign rd_valid = vld_q[LATENCY-1];

endmodule
`default_nettype wire

// File: rtl/asym_fifo_write_wider.sv
`default_nettype none
// ============================================================================
// Module   : asym_fifo_write_wider
// Brief    : Single-clock FIFO, wide words in, narrow sub-words out (LSB first).
//            Define ASYM_FIFO_LAST_EN to add s_last / m_last framing.
// Revision : 1.0 - initial release
// ============================================================================
module asym_fifo_write_wider
    import asym_fifo_write_wider_pkg::*;
#(
    parameter int WIDTH_W = 64,
    parameter int RATIO   = 8,
    parameter int WIDTH_R = WIDTH_W / RATIO,
    parameter int DEPTH_W = 256,
    parameter int LATENCY = 1,
    parameter int ADDR_W  = $clog2(DEPTH_W)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [WIDTH_W-1:0] s_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [WIDTH_R-1:0] m_data,
    output logic [ADDR_W:0]    count
`ifdef ASYM_FIFO_LAST_EN
    ,
    input  logic               s_last,
    output logic               m_last
`endif
);

    localparam int SUB_W = $clog2(RATIO);
`ifdef ASYM_FIFO_LAST_EN
    localparam int RAM_W = WIDTH_W + 1;
`else
    localparam int RAM_W = WIDTH_W;
`endif
    localparam logic [ADDR_W:0]  FULL_CNT = (ADDR_W+1)'(DEPTH_W);
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(RATIO - 1);

    rd_state_t          state, state_n;
    logic [ADDR_W-1:0]  wr_ptr, rd_ptr;
    logic [ADDR_W:0]    count_q;
    logic [SUB_W-1:0]   sub;
    logic [RAM_W-1:0]   cur, cur_n, nxt, nxt_n;
    logic               nxt_full, nxt_full_n;
    logic [1:0]         in_flight, occ;
    logic               wr_en, issue, beat, last_beat;
    logic [RAM_W-1:0]   ram_wdata, ret_data;
    logic               ret_valid;

    assign s_ready   = !rst && (count_q != FULL_CNT);
    assign wr_en     = s_valid && s_ready;
    // CUR and NXT plus reads in flight never exceed the two-word buffer.
    assign occ       = {1'b0, state == VALID} + {1'b0, nxt_full};
    assign issue     = (count_q != '0) && ((in_flight + occ) < 2'd2);
    assign beat      = (state == VALID) && m_ready;
    assign last_beat = beat && (sub == SUB_LAST);

`ifdef ASYM_FIFO_LAST_EN
    assign ram_wdata = {s_last, s_data};
`else
    assign ram_wdata = s_data;
`endif

    ram_sdp_wide #(
        .DW      (RAM_W),
        .DEPTH   (DEPTH_W),
        .AW      (ADDR_W),
        .LATENCY (LATENCY)
    ) u_ram (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_ptr),
        .wr_data  (ram_wdata),
        .rd_en    (issue),
        .rd_addr  (rd_ptr),
        .rd_data  (ret_data),
        .rd_valid (ret_valid)
    );

    always_comb begin
        state_n    = state;
        cur_n      = cur;
        nxt_n      = nxt;
        nxt_full_n = nxt_full;
        case (state)
            EMPTY: begin
                if (issue) state_n = WAIT;
            end
            WAIT: begin
                if (ret_valid) begin
                    state_n = VALID;
                    cur_n   = ret_data;
                end
            end
            VALID: begin
                if (last_beat) begin
                    // Reload CUR on the same edge the last sub-word leaves.
                    if (nxt_full) begin
                        cur_n      = nxt;
                        nxt_full_n = ret_valid;
                        if (ret_valid) nxt_n = ret_data;
                    end else if (ret_valid) begin
                        cur_n = ret_data;
                    end else if ((in_flight != 2'd0) || issue) begin
                        state_n = WAIT;
                    end else begin
                        state_n = EMPTY;
                    end
                end else if (ret_valid) begin
                    nxt_n      = ret_data;
                    nxt_full_n = 1'b1;
                end
            end
            default: state_n = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            cur       <= '0;
            nxt       <= '0;
            nxt_full  <= 1'b0;
            sub       <= '0;
            in_flight <= 2'd0;
            count_q   <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
        end else begin
            state     <= state_n;
            cur       <= cur_n;
            nxt       <= nxt_n;
            nxt_full  <= nxt_full_n;
            in_flight <= in_flight + {1'b0, issue} - {1'b0, ret_valid};
            if (beat)  sub    <= sub + SUB_W'(1);
            if (wr_en) wr_ptr <= wr_ptr + ADDR_W'(1);
            if (issue) rd_ptr <= rd_ptr + ADDR_W'(1);
            case ({wr_en, issue})
                2'b10:   count_q <= count_q + (ADDR_W+1)'(1);
                2'b01:   count_q <= count_q - (ADDR_W+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign m_valid = (state == VALID);
    assign m_data  = cur[int'(sub)*WIDTH_R +: WIDTH_R];
    assign count   = count_q;
`ifdef ASYM_FIFO_LAST_EN
    assign m_last  = m_valid && (sub == SUB_LAST) && cur[WIDTH_W];
`endif

endmodule
`default_nettype wire

// File: tb/tb_asym_fifo_write_wider.sv
`default_nettype none
// ============================================================================
// Module   : tb_asym_fifo_write_wider
// Brief    : Scoreboard bench: accepted wide words are split into expected
//            narrow beats; a monitor pops and compares each delivered beat.
// Revision : 1.0 - initial release
// ============================================================================
module tb_asym_fifo_write_wider;

    localparam int WIDTH_W = 64;
    localparam int RATIO   = 8;
    localparam int WIDTH_R = 8;
    localparam int DEPTH_W = 256;
    localparam int LATENCY = 1;
    localparam int ADDR_W  = 8;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               s_valid = 1'b0;
    logic               s_ready;
    logic [WIDTH_W-1:0] s_data = '0;
    logic               s_last = 1'b0;
    logic               m_valid;
    logic               m_ready = 1'b0;
    logic [WIDTH_R-1:0] m_data;
    logic [ADDR_W:0]    count;
`ifdef ASYM_FIFO_LAST_EN
    logic               m_last;
`endif

    always #5 clk = ~clk;

    asym_fifo_write_wider #(
        .WIDTH_W (WIDTH_W),
        .RATIO   (RATIO),
        .WIDTH_R (WIDTH_R),
        .DEPTH_W (DEPTH_W),
        .LATENCY (LATENCY),
        .ADDR_W  (ADDR_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .count   (count)
`ifdef ASYM_FIFO_LAST_EN
        ,
        .s_last  (s_last),
        .m_last  (m_last)
`endif
    );

    int               n_checks = 0;
    int               n_fail   = 0;
    logic [WIDTH_R:0] exp_q [$];
    logic [WIDTH_R:0] e;
    bit               track = 1'b0;
    int               beats = 0;
    int               gaps  = 0;
    bit               stalled = 1'b0;
    logic [WIDTH_R-1:0] stall_data;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got timeout, expected DUT response", name);
    endtask

    // Reference model + monitor: every accepted word becomes RATIO beats, LSB first.
    always @(negedge clk) begin
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (s_valid && s_ready) begin
                for (int k = 0; k < RATIO; k++) begin
                    exp_q.push_back({(s_last && (k == RATIO-1)), s_data[k*WIDTH_R +: WIDTH_R]});
                end
            end
            if (stalled) begin
                check("hold_valid", 64'(m_valid), 64'd1);
                check("hold_data", 64'(m_data), 64'(stall_data));
            end
            stalled    = m_valid && !m_ready;
            stall_data = m_data;
            if (track) begin
                if (m_valid && m_ready) beats++;
                else if (beats > 0 && beats < 32) gaps++;
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL beat_unexpected: got 0x%0h, expected no beat", m_data);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_data", 64'(m_data), 64'(e[WIDTH_R-1:0]));
`ifdef ASYM_FIFO_LAST_EN
                    check("beat_last", 64'(m_last), 64'(e[WIDTH_R]));
`endif
                end
            end
        end
    end

    // Call at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic write_word(input logic [63:0] d, input bit last);
        int t = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        @(negedge clk);
        while (!s_ready && t < 3000) begin
            t++;
            @(negedge clk);
        end
        if (!s_ready) timeout("write_accept");
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_drain(input int bound);
        int t = 0;
        while (exp_q.size() != 0 && t < bound) begin
            @(negedge clk);
            #1;
            t++;
        end
        check("drain_remaining", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int  accepted;
        int  t;
        bit  found;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_s_ready", 64'(s_ready), 64'd0);
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_s_ready", 64'(s_ready), 64'd1);

        // Single word: first beat after two edges, then 8 beats and empty
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        write_word(64'h0706050403020100, 1'b0);
        @(negedge clk);
        check("lat_after_e0", 64'(m_valid), 64'd0);
        @(negedge clk);
        check("lat_after_e1", 64'(m_valid), 64'd0);
        @(negedge clk);
        check("lat_after_e2", 64'(m_valid), 64'd1);
        check("lat_first_beat", 64'(m_data), 64'h00);
        wait_drain(50);
        @(negedge clk);
        check("single_done_valid", 64'(m_valid), 64'd0);
        check("single_done_count", 64'(count), 64'd0);

        // Fill with m_ready low: capacity is DEPTH_W + 2
        @(posedge clk);
        #1;
        m_ready  = 1'b0;
        accepted = 0;
        s_valid  = 1'b1;
        s_data   = 64'h1000;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (!s_ready) break;
            accepted++;
            @(posedge clk);
            #1;
            s_data = 64'h1000 + 64'(accepted);
        end
        check("full_accepted", 64'(accepted), 64'd258);
        check("full_count", 64'(count), 64'd256);
        check("full_s_ready", 64'(s_ready), 64'd0);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        for (int b = 0; b < 7; b++) begin
            m_ready = 1'b1;
            @(posedge clk);
            #1;
            m_ready = 1'b0;
            @(negedge clk);
            check("full_s_ready_held", 64'(s_ready), 64'd0);
            @(posedge clk);
            #1;
        end
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (s_ready) found = 1'b1;
        end
        check("full_s_ready_back", 64'(found), 64'd1);
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        wait_drain(3000);

        // Back-to-back words: 32 contiguous beats
        @(posedge clk);
        #1;
        track = 1'b1;
        beats = 0;
        gaps  = 0;
        for (int i = 0; i < 4; i++) write_word({$urandom, $urandom}, 1'b0);
        wait_drain(100);
        check("b2b_beats", 64'(beats), 64'd32);
        check("b2b_gaps", 64'(gaps), 64'd0);

        // m_ready toggling every cycle over 3 words
        @(posedge clk);
        #1;
        beats = 0;
        fork
            begin
                for (int i = 0; i < 3; i++) write_word({$urandom, $urandom}, 1'b0);
            end
            begin
                for (int c = 0; c < 80; c++) begin
                    m_ready = ~m_ready;
                    @(posedge clk);
                    #1;
                end
            end
        join
        m_ready = 1'b1;
        wait_drain(100);
        check("toggle_beats", 64'(beats), 64'd24);
        track = 1'b0;

        // Reset mid-stream, then no stale data
        @(posedge clk);
        #1;
        track = 1'b1;
        beats = 0;
        write_word(64'h1122334455667788, 1'b0);
        t = 0;
        while (beats < 3 && t < 50) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (beats < 3) timeout("rstmid_beats");
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("rstmid_m_valid", 64'(m_valid), 64'd0);
        check("rstmid_count", 64'(count), 64'd0);
        check("rstmid_s_ready", 64'(s_ready), 64'd0);
        exp_q.delete();
        track = 1'b0;
        @(negedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        write_word(64'hFFFF_FFFF_FFFF_FFF0, 1'b0);
        t = 0;
        while (!m_valid && t < 10) begin
            @(negedge clk);
            t++;
        end
        check("rstmid_first_beat", 64'(m_data), 64'hF0);
        wait_drain(50);

        // Framing: last flag only on beat 7 of the second word
        @(posedge clk);
        #1;
        write_word(64'hA7A6A5A4A3A2A1A0, 1'b0);
        write_word(64'hB7B6B5B4B3B2B1B0, 1'b1);
        wait_drain(50);

        // Randomised traffic with back-pressure
        @(posedge clk);
        #1;
        for (int c = 0; c < 600; c++) begin
            s_valid = 1'($urandom_range(0, 1));
            s_data  = {$urandom, $urandom};
            s_last  = 1'($urandom_range(0, 1));
            m_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        m_ready = 1'b1;
        wait_drain(3000);
        @(negedge clk);
        check("end_m_valid", 64'(m_valid), 64'd0);
        check("end_count", 64'(count), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion, expected end of test");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
